// File: rtl/fifo_pkg.sv
// Shared definitions for the narrow/wide FIFO queue controllers.
package fifo_pkg;

  // Number of register-file entries for a given address width.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // Occupancy counter width: one extra bit so that DEPTH itself is representable.
  function automatic int fifo_cnt_w(input int aw);
    return aw + 1;
  endfunction

  // Registered occupancy flags; at most one is set at any time.
  typedef struct packed {
    logic empty;
    logic full;
    logic one_stored;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ctrl_wide_rd.sv
// Circular-queue controller for a register file written one entry at a time
// and read two entries at a time. r_addr0 is the older entry (low half of the
// wide word), r_addr1 the newer one (high half). rd_ptr only ever advances by
// two from zero, so it stays even and a pair never straddles the wrap point.
module fifo_ctrl_wide_rd
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  empty,
  output logic                  full,
  output logic                  one_stored,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr0,
  output logic [ADDR_WIDTH-1:0] r_addr1
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  fifo_status_t          status_q;
  fifo_status_t          status_next;
  logic                  rd_ok;
  logic                  wr_ok;

  // Request semantics: rd and wr are single-cycle requests with no ready
  // return. A request is accepted in the cycle it is high if the registered
  // state allows it; a rejected request is dropped (no state change) and the
  // requester is expected to consult the flags. A read needs at least two
  // stored entries. A write needs space, or a same-cycle accepted read that
  // frees space. Pointers and flags reflect an accepted request one cycle later.
  assign rd_ok = rd & (count_q >= CNT_W'(2));
  assign wr_ok = wr & (~status_q.full | rd_ok);

  // Next occupancy: +1 per accepted write, -2 per accepted read.
  always_comb begin
    count_next = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(2);
      2'b11:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  // Flags are decoded from the next occupancy so they register alongside it.
  always_comb begin
    status_next.empty      = (count_next == CNT_W'(0));
    status_next.full       = (count_next == CNT_W'(DEPTH));
    status_next.one_stored = (count_next == CNT_W'(1));
  end

  // Pointer, occupancy and flag registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      status_q <= '{empty: 1'b1, full: 1'b0, one_stored: 1'b0};
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(2);
      count_q  <= count_next;
      status_q <= status_next;
    end
  end

  assign empty      = status_q.empty;
  assign full       = status_q.full;
  assign one_stored = status_q.one_stored;
  assign count      = count_q;
  assign w_addr     = wr_ptr;
  assign r_addr0    = rd_ptr;
  assign r_addr1    = rd_ptr + ADDR_WIDTH'(1);

endmodule
